// File: rtl/mem_sys_sequencer_if.sv
// Control/status bundle between the sequencer and memory_system.
// The sequencer (master) drives every memory_system control input and
// reads back the IR contents plus the ALU zero/carry flags.
interface mem_sys_sequencer_if;
  logic [4:0] instruction;
  logic       Z;
  logic       C;
  logic       ir_sclr;
  logic       mar_sclr;
  logic       enaf;
  logic       bank_wr_en;
  logic       ir_en;
  logic       mar_en;
  logic       wr_rdn;
  logic       mdr_alu_n;
  logic       mdr_en;
  logic [2:0] selop;
  logic [1:0] shamt;
  logic [2:0] busB_addr;
  logic [2:0] busC_addr;

  modport master (
    input  instruction, Z, C,
    output ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, wr_rdn,
           mdr_alu_n, mdr_en, selop, shamt, busB_addr, busC_addr
  );

  modport slave (
    output instruction, Z, C,
    input  ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, wr_rdn,
           mdr_alu_n, mdr_en, selop, shamt, busB_addr, busC_addr
  );
endinterface

// File: rtl/mem_sys_sequencer.sv
// Hardwired control FSM for memory_system: fetch (MAR <- PC, MDR <- mem,
// IR <- MDR, PC <- PC+1), decode, then one to three execute micro-steps.
// Outputs are decoded from the state register; DEC and XA additionally
// look at the IR contents (and DEC at the flags) in the same cycle.
module mem_sys_sequencer (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  mem_sys_sequencer_if.master        mem,
  output logic                       busy,
  output logic                       halted,
  output logic                       instr_done,
  output logic                       illegal_op
);

  localparam logic [2:0] OP_PASSB  = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] ADDR_PC   = 3'd0;
  localparam logic [2:0] ADDR_DPTR = 3'd1;
  localparam logic [2:0] ADDR_A    = 3'd2;
  localparam logic [2:0] ADDR_TEMP = 3'd3;
  localparam logic [2:0] ADDR_ACC  = 3'd4;
  localparam logic [2:0] ADDR_MDR  = 3'd5;

  // Busy states occupy the contiguous range S_CLR..S_XJ.
  localparam logic [4:0] S_IDLE = 5'd0;
  localparam logic [4:0] S_CLR  = 5'd1;
  localparam logic [4:0] S_F0   = 5'd2;
  localparam logic [4:0] S_F1   = 5'd3;
  localparam logic [4:0] S_F2   = 5'd4;
  localparam logic [4:0] S_F3   = 5'd5;
  localparam logic [4:0] S_DEC  = 5'd6;
  localparam logic [4:0] S_L0   = 5'd7;
  localparam logic [4:0] S_L1   = 5'd8;
  localparam logic [4:0] S_L2   = 5'd9;
  localparam logic [4:0] S_S0   = 5'd10;
  localparam logic [4:0] S_S1   = 5'd11;
  localparam logic [4:0] S_S2   = 5'd12;
  localparam logic [4:0] S_XI   = 5'd13;
  localparam logic [4:0] S_XA   = 5'd14;
  localparam logic [4:0] S_XJ   = 5'd15;
  localparam logic [4:0] S_HALT = 5'd16;

  logic [4:0] state;
  logic [4:0] state_nxt;

  // State register; reset forces IDLE at once, even mid-instruction.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; DEC dispatches on the opcode and the current flags.
  // NOTE: the default assignment at the top of every always_comb keeps
  // each path fully specified, so no latch is inferred.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: state_nxt = start ? S_CLR : S_IDLE;
      S_CLR:  state_nxt = S_F0;
      S_F0:   state_nxt = S_F1;
      S_F1:   state_nxt = S_F2;
      S_F2:   state_nxt = S_F3;
      S_F3:   state_nxt = S_DEC;
      S_DEC: begin
        casez (mem.instruction)
          5'b00001: state_nxt = S_L0;
          5'b00010: state_nxt = S_S0;
          5'b00011: state_nxt = S_XI;
          5'b00101: state_nxt = mem.Z ? S_XJ : S_F0;
          5'b00110: state_nxt = mem.C ? S_XJ : S_F0;
          5'b01???: state_nxt = S_XA;
          5'b11111: state_nxt = S_HALT;
          default:  state_nxt = S_F0;  // NOP and undefined opcodes
        endcase
      end
      S_L0:   state_nxt = S_L1;
      S_L1:   state_nxt = S_L2;
      S_S0:   state_nxt = S_S1;
      S_S1:   state_nxt = S_S2;
      S_L2, S_S2, S_XI, S_XA, S_XJ: state_nxt = S_F0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;     // unused encodings recover
    endcase
  end

  // Control decode: everything low unless the current state asks for it.
  always_comb begin
    mem.ir_sclr    = 1'b0;
    mem.mar_sclr   = 1'b0;
    mem.enaf       = 1'b0;
    mem.bank_wr_en = 1'b0;
    mem.ir_en      = 1'b0;
    mem.mar_en     = 1'b0;
    mem.wr_rdn     = 1'b0;
    mem.mdr_alu_n  = 1'b0;
    mem.mdr_en     = 1'b0;
    mem.selop      = OP_PASSB;
    mem.shamt      = 2'b00;
    mem.busB_addr  = ADDR_PC;
    mem.busC_addr  = ADDR_PC;
    halted         = 1'b0;
    instr_done     = 1'b0;
    illegal_op     = 1'b0;
    case (state)
      S_CLR: begin
        mem.ir_sclr  = 1'b1;
        mem.mar_sclr = 1'b1;
      end
      S_F0, S_L0, S_S0: begin
        // MAR <- PC for fetch, MAR <- DPTR for load/store.
        mem.busB_addr = (state == S_F0) ? ADDR_PC : ADDR_DPTR;
        mem.mar_en    = 1'b1;
      end
      S_F1, S_L1: begin
        mem.mdr_alu_n = 1'b1;
        mem.mdr_en    = 1'b1;
      end
      S_F2: mem.ir_en = 1'b1;
      S_F3: begin
        mem.selop      = OP_INC;
        mem.bank_wr_en = 1'b1;
      end
      S_DEC: begin
        casez (mem.instruction)
          5'b00000, 5'b11111: instr_done = 1'b1;
          5'b00001, 5'b00010, 5'b00011, 5'b01???: instr_done = 1'b0;
          5'b00101: instr_done = ~mem.Z;
          5'b00110: instr_done = ~mem.C;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_L2: begin
        mem.busB_addr  = ADDR_MDR;
        mem.busC_addr  = ADDR_A;
        mem.bank_wr_en = 1'b1;
        instr_done     = 1'b1;
      end
      S_S1: begin
        mem.busB_addr = ADDR_ACC;
        mem.mdr_en    = 1'b1;
      end
      S_S2: begin
        mem.wr_rdn = 1'b1;
        instr_done = 1'b1;
      end
      S_XI: begin
        mem.busB_addr  = ADDR_DPTR;
        mem.busC_addr  = ADDR_DPTR;
        mem.selop      = OP_INC;
        mem.bank_wr_en = 1'b1;
        instr_done     = 1'b1;
      end
      S_XA: begin
        mem.busB_addr  = ADDR_TEMP;
        mem.busC_addr  = ADDR_ACC;
        mem.selop      = mem.instruction[2:0];
        mem.enaf       = 1'b1;
        mem.bank_wr_en = 1'b1;
        instr_done     = 1'b1;
      end
      S_XJ: begin
        mem.busB_addr  = ADDR_DPTR;
        mem.busC_addr  = ADDR_PC;
        mem.bank_wr_en = 1'b1;
        instr_done     = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // Busy covers every state from CLR through the execute steps.
  assign busy = (state >= S_CLR) && (state <= S_XJ);

endmodule

// File: tb/tb_mem_sys_sequencer.sv
// Directed bench for mem_sys_sequencer: a per-cycle table of inputs and
// expected control words, followed by a hand-written async-reset sequence.
module tb_mem_sys_sequencer;

  typedef struct packed {
    logic       ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en;
    logic       wr_rdn, mdr_alu_n, mdr_en;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic [2:0] busb, busc;
    logic       busy, halted, instr_done, illegal_op;
  } out_t;

  typedef struct {
    logic       start;
    logic [4:0] instr;
    logic       z, c;
    out_t       exp;
    string      name;
  } vec_t;

  localparam out_t E_IDLE = '0;
  localparam out_t E_CLR  = '{ir_sclr: 1'b1, mar_sclr: 1'b1, busy: 1'b1, default: '0};
  localparam out_t E_F0   = '{mar_en: 1'b1, busy: 1'b1, default: '0};
  localparam out_t E_F1   = '{mdr_alu_n: 1'b1, mdr_en: 1'b1, busy: 1'b1, default: '0};
  localparam out_t E_F2   = '{ir_en: 1'b1, busy: 1'b1, default: '0};
  localparam out_t E_F3   = '{bank_wr_en: 1'b1, selop: 3'b001, busy: 1'b1, default: '0};
  localparam out_t E_DEC  = '{busy: 1'b1, default: '0};
  localparam out_t E_DDON = '{busy: 1'b1, instr_done: 1'b1, default: '0};
  localparam out_t E_DILL = '{busy: 1'b1, instr_done: 1'b1, illegal_op: 1'b1, default: '0};
  localparam out_t E_L0   = '{mar_en: 1'b1, busb: 3'd1, busy: 1'b1, default: '0};
  localparam out_t E_L2   = '{busb: 3'd5, busc: 3'd2, bank_wr_en: 1'b1, instr_done: 1'b1,
                              busy: 1'b1, default: '0};
  localparam out_t E_S1   = '{busb: 3'd4, mdr_en: 1'b1, busy: 1'b1, default: '0};
  localparam out_t E_S2   = '{wr_rdn: 1'b1, instr_done: 1'b1, busy: 1'b1, default: '0};
  localparam out_t E_XI   = '{busb: 3'd1, busc: 3'd1, selop: 3'b001, bank_wr_en: 1'b1,
                              instr_done: 1'b1, busy: 1'b1, default: '0};
  localparam out_t E_XA   = '{busb: 3'd3, busc: 3'd4, selop: 3'b011, enaf: 1'b1,
                              bank_wr_en: 1'b1, instr_done: 1'b1, busy: 1'b1, default: '0};
  localparam out_t E_XJ   = '{busb: 3'd1, busc: 3'd0, bank_wr_en: 1'b1, instr_done: 1'b1,
                              busy: 1'b1, default: '0};
  localparam out_t E_HALT = '{halted: 1'b1, default: '0};

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, halted, instr_done, illegal_op;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  mem_sys_sequencer_if bus ();

  mem_sys_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem        (bus),
    .busy       (busy),
    .halted     (halted),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t o;
    o.ir_sclr    = bus.ir_sclr;
    o.mar_sclr   = bus.mar_sclr;
    o.enaf       = bus.enaf;
    o.bank_wr_en = bus.bank_wr_en;
    o.ir_en      = bus.ir_en;
    o.mar_en     = bus.mar_en;
    o.wr_rdn     = bus.wr_rdn;
    o.mdr_alu_n  = bus.mdr_alu_n;
    o.mdr_en     = bus.mdr_en;
    o.selop      = bus.selop;
    o.shamt      = bus.shamt;
    o.busb       = bus.busB_addr;
    o.busc       = bus.busC_addr;
    o.busy       = busy;
    o.halted     = halted;
    o.instr_done = instr_done;
    o.illegal_op = illegal_op;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t got;
    got = sample();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h want %06h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, compare mid-cycle, then advance to the next negedge.
  task automatic step(input logic s, input logic [4:0] i, input logic z,
                      input logic c, input out_t exp, input string name);
    start = s;
    bus.instruction = i;
    bus.Z = z;
    bus.C = c;
    #1;
    check(name, exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic s, input logic [4:0] i, input logic z,
                     input logic c, input out_t exp, input string name);
    vec_t v;
    v.start = s; v.instr = i; v.z = z; v.c = c; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [4:0] i);
    add(1'b0, i, 1'b0, 1'b0, E_F0, "F0");
    add(1'b0, i, 1'b0, 1'b0, E_F1, "F1");
    add(1'b0, i, 1'b0, 1'b0, E_F2, "F2");
    add(1'b0, i, 1'b0, 1'b0, E_F3, "F3");
  endtask

  initial begin
    out_t e_xa6;
    e_xa6 = E_XA;
    e_xa6.selop = 3'b110;

    // Power-on through NOP.
    add(1'b0, 5'b00000, 1'b0, 1'b0, E_IDLE, "idle");
    add(1'b1, 5'b00000, 1'b0, 1'b0, E_IDLE, "idle_start");
    add(1'b0, 5'b00000, 1'b0, 1'b0, E_CLR,  "clr");
    add_fetch(5'b00000);
    add(1'b0, 5'b00000, 1'b0, 1'b0, E_DDON, "nop_dec");
    // LDA, with a stray start pulse in L1.
    add_fetch(5'b00001);
    add(1'b0, 5'b00001, 1'b0, 1'b0, E_DEC,  "lda_dec");
    add(1'b0, 5'b00001, 1'b0, 1'b0, E_L0,   "lda_l0");
    add(1'b1, 5'b00001, 1'b0, 1'b0, E_F1,   "lda_l1");
    add(1'b0, 5'b00001, 1'b0, 1'b0, E_L2,   "lda_l2");
    // STA.
    add_fetch(5'b00010);
    add(1'b0, 5'b00010, 1'b0, 1'b0, E_DEC,  "sta_dec");
    add(1'b0, 5'b00010, 1'b0, 1'b0, E_L0,   "sta_s0");
    add(1'b0, 5'b00010, 1'b0, 1'b0, E_S1,   "sta_s1");
    add(1'b0, 5'b00010, 1'b0, 1'b0, E_S2,   "sta_s2");
    // INCD.
    add_fetch(5'b00011);
    add(1'b0, 5'b00011, 1'b0, 1'b0, E_DEC,  "incd_dec");
    add(1'b0, 5'b00011, 1'b0, 1'b0, E_XI,   "incd_xi");
    // ALU ops with two different selop fields.
    add_fetch(5'b01011);
    add(1'b0, 5'b01011, 1'b0, 1'b0, E_DEC,  "alu3_dec");
    add(1'b0, 5'b01011, 1'b0, 1'b0, E_XA,   "alu3_xa");
    add_fetch(5'b01110);
    add(1'b0, 5'b01110, 1'b0, 1'b0, E_DEC,  "alu6_dec");
    add(1'b0, 5'b01110, 1'b0, 1'b0, e_xa6,  "alu6_xa");
    // JZ taken / not taken.
    add_fetch(5'b00101);
    add(1'b0, 5'b00101, 1'b1, 1'b0, E_DEC,  "jz1_dec");
    add(1'b0, 5'b00101, 1'b1, 1'b0, E_XJ,   "jz1_xj");
    add_fetch(5'b00101);
    add(1'b0, 5'b00101, 1'b0, 1'b1, E_DDON, "jz0_dec");
    // JC taken / not taken.
    add_fetch(5'b00110);
    add(1'b0, 5'b00110, 1'b0, 1'b1, E_DEC,  "jc1_dec");
    add(1'b0, 5'b00110, 1'b0, 1'b1, E_XJ,   "jc1_xj");
    add_fetch(5'b00110);
    add(1'b0, 5'b00110, 1'b1, 1'b0, E_DDON, "jc0_dec");
    // Undefined opcodes.
    add_fetch(5'b10000);
    add(1'b0, 5'b10000, 1'b0, 1'b0, E_DILL, "ill10_dec");
    add_fetch(5'b00100);
    add(1'b0, 5'b00100, 1'b0, 1'b0, E_DILL, "ill04_dec");
    add_fetch(5'b00111);
    add(1'b0, 5'b00111, 1'b0, 1'b0, E_DILL, "ill07_dec");
    add(1'b0, 5'b00111, 1'b0, 1'b0, E_F0,   "ill_to_f0");
    add(1'b0, 5'b00111, 1'b0, 1'b0, E_F1,   "F1");
    add(1'b0, 5'b00111, 1'b0, 1'b0, E_F2,   "F2");
    add(1'b0, 5'b11111, 1'b0, 1'b0, E_F3,   "F3");
    // HLT, then 20 cycles of HALT with start toggling.
    add(1'b0, 5'b11111, 1'b0, 1'b0, E_DDON, "hlt_dec");
    for (int k = 0; k < 20; k++)
      add(k[0], 5'b11111, 1'b0, 1'b0, E_HALT, "halt_hold");

    rst = 1'b0;
    start = 1'b0;
    bus.instruction = '0;
    bus.Z = 1'b0;
    bus.C = 1'b0;
    #1;
    check("reset_state", E_IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k])
      step(vecs[k].start, vecs[k].instr, vecs[k].z, vecs[k].c, vecs[k].exp, vecs[k].name);

    // HALT is left only through reset; then run STA to S1 and reset there.
    rst = 1'b0;
    #1;
    check("halt_rst", E_IDLE);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 5'b00010, 1'b0, 1'b0, E_IDLE, "r_idle_start");
    step(1'b0, 5'b00010, 1'b0, 1'b0, E_CLR,  "r_clr");
    step(1'b0, 5'b00010, 1'b0, 1'b0, E_F0,   "r_f0");
    step(1'b0, 5'b00010, 1'b0, 1'b0, E_F1,   "r_f1");
    step(1'b0, 5'b00010, 1'b0, 1'b0, E_F2,   "r_f2");
    step(1'b0, 5'b00010, 1'b0, 1'b0, E_F3,   "r_f3");
    step(1'b0, 5'b00010, 1'b0, 1'b0, E_DEC,  "r_dec");
    step(1'b0, 5'b00010, 1'b0, 1'b0, E_L0,   "r_s0");
    #1;
    check("r_s1", E_S1);
    // Asynchronous: outputs must clear before any clock edge.
    #1 rst = 1'b0;
    #1;
    check("r_async_clear", E_IDLE);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++)
      step(1'b0, 5'b00010, 1'b0, 1'b0, E_IDLE, "r_idle_wait");
    step(1'b1, 5'b00010, 1'b0, 1'b0, E_IDLE, "r_idle_start2");
    step(1'b0, 5'b00010, 1'b0, 1'b0, E_CLR,  "r_clr2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
